// File: rtl/recip_edge_counter.sv
// -----------------------------------------------------------------------------
// recip_edge_counter
//
// Upstream measurement core of a single-channel reciprocal frequency counter.
// The raw sensor input is synchronised and its rising edges detected.  A run
// counts the clk cycles that span N whole sensor periods (N+1 rising edges).
// The result is handed downstream with a level valid / pulse ack handshake.
// The host computes f = N * F_clk / coarse.
//
// Optional feature macro: RECIP_TIMEOUT_EN
//   When defined, a run that sees no sensor edge for TIMEOUT_CYCLES clk
//   cycles while in ARM or COUNT is aborted.  It still reports a result, with
//   meas_timeout_o set.  When undefined, the block waits indefinitely and
//   meas_timeout_o is always 0.
//
// Ports:
//   clk            measurement clock (sole clock domain)
//   rst_n          asynchronous active-low reset
//   sensor_i       raw asynchronous sensor square wave
//   enable_i       run measurements while high
//   n_cycles_i     requested sensor periods per run (0 treated as 1)
//   busy_o         high in ARM, COUNT or DONE (registered)
//   meas_valid_o   result available, held until acked
//   meas_ack_i     one-cycle consume pulse from downstream
//   meas_coarse_o  clk cycles from start edge to stop edge
//   meas_n_o       periods actually measured
//   meas_ovf_o     coarse counter saturated
//   meas_timeout_o run ended by timeout
// -----------------------------------------------------------------------------
module recip_edge_counter #(
    parameter int unsigned COARSE_WIDTH   = 24,
    parameter int unsigned N_WIDTH        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sensor_i,
    input  logic                    enable_i,
    input  logic [N_WIDTH-1:0]      n_cycles_i,
    output logic                    busy_o,
    output logic                    meas_valid_o,
    input  logic                    meas_ack_i,
    output logic [COARSE_WIDTH-1:0] meas_coarse_o,
    output logic [N_WIDTH-1:0]      meas_n_o,
    output logic                    meas_ovf_o,
    output logic                    meas_timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Synchroniser and edge-detect registers
    logic sync1_q;
    logic sync2_q;
    logic sens_dly_q;
    logic edge_p;

    // FSM state, counters and registered outputs
    state_e                  state_q;
    logic [N_WIDTH-1:0]      n_req_q;
    logic [COARSE_WIDTH-1:0] coarse_cnt_q;
    logic [N_WIDTH-1:0]      edge_cnt_q;
    logic                    ovf_flag_q;
    logic                    busy_q;
    logic                    meas_valid_q;
    logic [COARSE_WIDTH-1:0] meas_coarse_q;
    logic [N_WIDTH-1:0]      meas_n_q;
    logic                    meas_ovf_q;
    logic                    meas_timeout_q;

    // Next-value helpers
    logic [N_WIDTH-1:0]      n_req_d;
    logic [COARSE_WIDTH-1:0] coarse_inc_d;
    logic                    coarse_sat_d;
    logic [N_WIDTH-1:0]      edge_inc_d;
    logic                    stop_hit_d;
    logic                    timeout_d;

    // Two-flop synchroniser followed by a delay flop for rising-edge detect.
    // edge_p is seen by the FSM on the third clk edge after the sensor rises;
    // start and stop share this latency so it cancels in the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sens_dly_q <= 1'b0;
        end else begin
            sync1_q    <= sensor_i;
            sync2_q    <= sync1_q;
            sens_dly_q <= sync2_q;
        end
    end

    assign edge_p = sync2_q & ~sens_dly_q;

    always_comb begin
        n_req_d      = (n_cycles_i == '0) ? {{(N_WIDTH-1){1'b0}}, 1'b1} : n_cycles_i;
        // Saturating increment: stays at all-ones once there
        coarse_inc_d = (&coarse_cnt_q) ? coarse_cnt_q : coarse_cnt_q + 1'b1;
        coarse_sat_d = &coarse_inc_d;
        edge_inc_d   = edge_cnt_q + 1'b1;
        stop_hit_d   = edge_p && (edge_inc_d == n_req_q);
    end

`ifdef RECIP_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_cnt_q;

    assign timeout_d = (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES));

    // Cycles since the last sensor edge.  Held at 0 outside ARM/COUNT, so
    // every entry to ARM starts from a cleared count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
        end else if ((state_q == S_ARM || state_q == S_COUNT) && !edge_p) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
        end else begin
            idle_cnt_q <= '0;
        end
    end
`else
    assign timeout_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            n_req_q        <= '0;
            coarse_cnt_q   <= '0;
            edge_cnt_q     <= '0;
            ovf_flag_q     <= 1'b0;
            busy_q         <= 1'b0;
            meas_valid_q   <= 1'b0;
            meas_coarse_q  <= '0;
            meas_n_q       <= '0;
            meas_ovf_q     <= 1'b0;
            meas_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable_i) begin
                        n_req_q <= n_req_d;
                        state_q <= S_ARM;
                        busy_q  <= 1'b1;
                    end
                end

                S_ARM: begin
                    if (!enable_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (edge_p) begin
                        // Start edge: coarse_cnt counts cycles after it
                        coarse_cnt_q <= '0;
                        edge_cnt_q   <= '0;
                        ovf_flag_q   <= 1'b0;
                        state_q      <= S_COUNT;
                    end else if (timeout_d) begin
                        meas_coarse_q  <= '0;
                        meas_n_q       <= '0;
                        meas_ovf_q     <= 1'b0;
                        meas_timeout_q <= 1'b1;
                        meas_valid_q   <= 1'b1;
                        state_q        <= S_DONE;
                    end
                end

                S_COUNT: begin
                    if (!enable_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        coarse_cnt_q <= coarse_inc_d;
                        if (coarse_sat_d) begin
                            ovf_flag_q <= 1'b1;
                        end
                        if (edge_p) begin
                            edge_cnt_q <= edge_inc_d;
                            if (stop_hit_d) begin
                                // coarse_cnt lags the cycle index by one, so
                                // the incremented value is the edge distance
                                meas_coarse_q  <= coarse_inc_d;
                                meas_n_q       <= n_req_q;
                                meas_ovf_q     <= ovf_flag_q | coarse_sat_d;
                                meas_timeout_q <= 1'b0;
                                meas_valid_q   <= 1'b1;
                                state_q        <= S_DONE;
                            end
                        end else if (timeout_d) begin
                            meas_coarse_q  <= coarse_cnt_q;
                            meas_n_q       <= edge_cnt_q;
                            meas_ovf_q     <= ovf_flag_q;
                            meas_timeout_q <= 1'b1;
                            meas_valid_q   <= 1'b1;
                            state_q        <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    // Result held until consumed; the stop edge has already
                    // been used, so ARM waits for a fresh start edge.
                    if (meas_ack_i) begin
                        meas_valid_q <= 1'b0;
                        if (enable_i) begin
                            state_q <= S_ARM;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o         = busy_q;
    assign meas_valid_o   = meas_valid_q;
    assign meas_coarse_o  = meas_coarse_q;
    assign meas_n_o       = meas_n_q;
    assign meas_ovf_o     = meas_ovf_q;
    assign meas_timeout_o = meas_timeout_q;

endmodule

// File: tb/tb_recip_edge_counter.sv
// -----------------------------------------------------------------------------
// Testbench for recip_edge_counter.  Two instances share clk, rst_n and the
// sensor: a 24-bit coarse instance for most runs and an 8-bit one for the
// saturation case.  Both use TIMEOUT_CYCLES = 1000.
// -----------------------------------------------------------------------------
module tb_recip_edge_counter;

    localparam int CLK_HALF = 5;

    logic        clk;
    logic        rst_n;
    logic        gen_s;
    logic        man_s;
    logic        sensor;
    int          sen_per;

    // Main instance
    logic        en;
    logic [15:0] ncyc;
    logic        ack;
    logic        busy;
    logic        valid;
    logic [23:0] coarse;
    logic [15:0] mn;
    logic        ovf;
    logic        tmo;

    // Narrow-coarse instance
    logic        en_s;
    logic [15:0] ncyc_s;
    logic        ack_s;
    logic        busy_s;
    logic        valid_s;
    logic [7:0]  coarse_s;
    logic [15:0] mn_s;
    logic        ovf_s;
    logic        tmo_s;

    int n_cmp;
    int n_bad;

    assign sensor = gen_s | man_s;

    recip_edge_counter #(
        .COARSE_WIDTH(24), .N_WIDTH(16), .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sensor_i(sensor), .enable_i(en),
        .n_cycles_i(ncyc), .busy_o(busy), .meas_valid_o(valid),
        .meas_ack_i(ack), .meas_coarse_o(coarse), .meas_n_o(mn),
        .meas_ovf_o(ovf), .meas_timeout_o(tmo)
    );

    recip_edge_counter #(
        .COARSE_WIDTH(8), .N_WIDTH(16), .TIMEOUT_CYCLES(1000)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .sensor_i(sensor), .enable_i(en_s),
        .n_cycles_i(ncyc_s), .busy_o(busy_s), .meas_valid_o(valid_s),
        .meas_ack_i(ack_s), .meas_coarse_o(coarse_s), .meas_n_o(mn_s),
        .meas_ovf_o(ovf_s), .meas_timeout_o(tmo_s)
    );

    initial begin
        clk = 1'b0;
        forever #CLK_HALF clk = ~clk;
    end

    // Periodic sensor: high for per/2 cycles, low for the rest; 0 stops it
    initial begin
        int ph;
        ph    = 0;
        gen_s = 1'b0;
        forever begin
            @(negedge clk);
            if (sen_per == 0) begin
                gen_s = 1'b0;
                ph    = 0;
            end else begin
                gen_s = (ph < sen_per / 2);
                ph    = (ph + 1 >= sen_per) ? 0 : ph + 1;
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_valid(input bit narrow, input int bound, input string name);
        int n;
        n = 0;
        while (((narrow ? valid_s : valid) !== 1'b1) && n < bound) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if ((narrow ? valid_s : valid) !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: valid not seen within %0d cycles, expected 1", name, bound);
        end
    endtask

    // One-cycle ack; valid must be low at the following sample point
    task automatic ack_pulse(input string name);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk(name, valid, 0);
    endtask

    task automatic check_result(input string name, input longint c, input longint n,
                                input longint o, input longint t);
        chk({name, "_coarse"}, coarse, c);
        chk({name, "_n"}, mn, n);
        chk({name, "_ovf"}, ovf, o);
        chk({name, "_timeout"}, tmo, t);
    endtask

    typedef struct {
        int per;
        int n_in;
        int exp_coarse;
        int exp_n;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [23:0] snap_c;
        logic [15:0] snap_n;
        logic        snap_v;
        bit          stable;

        vecs[0] = '{per: 37, n_in: 0,  exp_coarse: 37,  exp_n: 1};
        vecs[1] = '{per: 13, n_in: 5,  exp_coarse: 65,  exp_n: 5};
        vecs[2] = '{per: 7,  n_in: 3,  exp_coarse: 21,  exp_n: 3};
        vecs[3] = '{per: 50, n_in: 1,  exp_coarse: 50,  exp_n: 1};
        vecs[4] = '{per: 24, n_in: 17, exp_coarse: 408, exp_n: 17};

        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        man_s   = 1'b0;
        sen_per = 0;
        en      = 1'b0;
        ncyc    = '0;
        ack     = 1'b0;
        en_s    = 1'b0;
        ncyc_s  = '0;
        ack_s   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        check_result("rst", 0, 0, 0, 0);
        rst_n = 1'b1;

        // Period 20, N=400, held result, ack, back-to-back second run
        sen_per = 20;
        ncyc    = 16'd400;
        repeat (50) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        chk("busy_after_enable", busy, 1);
        wait_valid(0, 8200, "t1_valid");
        check_result("t1", 8000, 400, 0, 0);
        snap_c = coarse;
        snap_n = mn;
        snap_v = valid;
        stable = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (coarse !== snap_c || mn !== snap_n || valid !== snap_v) stable = 1'b0;
        end
        chk("t1_hold_stable", stable, 1);
        ack_pulse("t1_valid_fall");
        wait_valid(0, 8200, "t1b_valid");
        check_result("t1b", 8000, 400, 0, 0);
        ack_pulse("t1b_valid_fall");

        // Table of single runs, each from a settled sensor
        for (int i = 0; i < 5; i++) begin
            en      = 1'b0;
            sen_per = vecs[i].per;
            ncyc    = 16'(vecs[i].n_in);
            repeat (3 * vecs[i].per + 10) @(negedge clk);
            en = 1'b1;
            wait_valid(0, vecs[i].exp_coarse + 4 * vecs[i].per + 50, $sformatf("vec%0d_valid", i));
            check_result($sformatf("vec%0d", i), vecs[i].exp_coarse, vecs[i].exp_n, 0, 0);
            ack_pulse($sformatf("vec%0d_valid_fall", i));
        end
        en = 1'b0;

        // Coarse saturation on the 8-bit instance: 10 x 40 = 400 > 255
        sen_per = 40;
        ncyc_s  = 16'd10;
        repeat (130) @(negedge clk);
        en_s = 1'b1;
        wait_valid(1, 700, "sat_valid");
        chk("sat_coarse", coarse_s, 255);
        chk("sat_ovf", ovf_s, 1);
        chk("sat_n", mn_s, 10);
        en_s = 1'b0;
        @(negedge clk);
        ack_s = 1'b1;
        @(negedge clk);
        ack_s = 1'b0;
        chk("sat_valid_fall", valid_s, 0);

        // Enable dropped for one cycle mid-COUNT, then a clean restart
        sen_per = 20;
        ncyc    = 16'd50;
        repeat (70) @(negedge clk);
        en = 1'b1;
        repeat (200) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("drop_busy", busy, 0);
        chk("drop_valid", valid, 0);
        en = 1'b1;
        wait_valid(0, 1200, "drop_restart_valid");
        check_result("drop_restart", 1000, 50, 0, 0);
        en = 1'b0;
        ack_pulse("drop_valid_fall");

        // Ack while no result is pending has no effect
        ncyc = 16'd20;
        repeat (10) @(negedge clk);
        en = 1'b1;
        repeat (100) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("stray_ack_busy", busy, 1);
        wait_valid(0, 600, "stray_ack_valid");
        check_result("stray_ack", 400, 20, 0, 0);
        ack_pulse("stray_ack_valid_fall");

        // Asynchronous reset mid-COUNT, between clock edges
        repeat (100) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", valid, 0);
        check_result("arst", 0, 0, 0, 0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_idle_busy", busy, 0);

        // Sensor stops after 3 periods of 20 clk; N=10 is never reached
        sen_per = 0;
        ncyc    = 16'd10;
        repeat (10) @(negedge clk);
        en = 1'b1;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            man_s = 1'b1;
            repeat (10) @(negedge clk);
            man_s = 1'b0;
            repeat (10) @(negedge clk);
        end
`ifdef RECIP_TIMEOUT_EN
        wait_valid(0, 1300, "tmo_count_valid");
        check_result("tmo_count", 1060, 3, 0, 1);
        ack_pulse("tmo_count_valid_fall");
        // No sensor edges at all: times out in ARM
        wait_valid(0, 1100, "tmo_arm_valid");
        check_result("tmo_arm", 0, 0, 0, 1);
        en = 1'b0;
        ack_pulse("tmo_arm_valid_fall");
`else
        repeat (1500) @(negedge clk);
        chk("notmo_busy", busy, 1);
        chk("notmo_valid", valid, 0);
        chk("notmo_timeout", tmo, 0);
        en = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/recip_edge_counter.md
Name: recip_edge_counter

Overview:
Upstream measurement core of the single-channel reciprocal frequency counter. Synchronises the raw sensor input and detects its rising edges. Measures the number of clk cycles spanning N whole sensor periods (N+1 rising edges) and hands the result downstream over a level valid / pulse ack handshake. The downstream UART framing stage consumes meas_coarse and meas_n; the host computes f = N * F_clk / coarse.

Parameters:
COARSE_WIDTH, 24, width of the coarse clk-cycle count.
N_WIDTH, 16, width of the period-count input and output.
TIMEOUT_CYCLES, 1048576, clk cycles without a sensor edge before a measurement aborts. Used only with RECIP_TIMEOUT_EN.

Ports:
clk  in  1  measurement clock; the sole clock domain.
rst_n  in  1  asynchronous, active-low reset.
sensor_in  in  1  raw asynchronous sensor square wave.
enable  in  1  run measurements while high.
n_cycles  in  N_WIDTH  requested sensor periods per measurement; latched at arm.
busy  out  1  high in ARM, COUNT or DONE.
meas_valid  out  1  result available; held until acked.
meas_ack  in  1  one-cycle consume pulse from downstream.
meas_coarse  out  COARSE_WIDTH  clk cycles from start edge to stop edge.
meas_n  out  N_WIDTH  periods actually measured.
meas_ovf  out  1  coarse counter saturated.
meas_timeout  out  1  measurement ended by timeout.

Behaviour:
- Reset: clk and rst_n, asynchronous and active-low. All outputs are 0 and the state is IDLE. The 2-FF synchroniser and the edge-detect register are cleared. A reset mid-measurement discards the measurement with no output.
- Edge detect: two-flop synchroniser plus a one-register edge detector. edge_p fires on the third clk edge after the sensor rises. Start and stop see the same delay, so it cancels in the result.
- States:
  - IDLE: if enable is high, latch n_req = max(n_cycles, 1) and go to ARM. n_cycles = 0 is treated as 1.
  - ARM: on edge_p, clear coarse_cnt and edge_cnt to 0 and go to COUNT.
  - COUNT: coarse_cnt increments every cycle and saturates at all-ones, which sets ovf_flag. On each edge_p, edge_cnt increments. When the incremented edge_cnt equals n_req, capture the outputs in the same cycle: meas_coarse = coarse_cnt + 1 (saturating), meas_n = n_req, meas_ovf, and meas_timeout = 0. meas_valid rises on the next cycle. Then go to DONE.
  - DONE: hold all meas_* stable. On meas_ack: meas_valid falls on the next cycle. Go to ARM if enable is high, otherwise go to IDLE. The stop edge is not reused as the next start edge.
- Coarse definition: meas_coarse is the difference in clk-cycle index between the start edge_p and the stop edge_p.
- enable low in ARM or COUNT: go to IDLE next cycle and emit no result. enable low in DONE: the result is still held until acked.
- meas_ack while meas_valid = 0: ignored.
- meas_valid must be a level. No new result may overwrite an unacked one.
- busy = (state != IDLE), registered.
- Sensor glitches shorter than one clk period may be missed. This is acceptable.

Optional Feature:
RECIP_TIMEOUT_EN
- Defined: an idle counter clears on every edge_p and on entry to ARM, and increments in ARM and COUNT. When it reaches TIMEOUT_CYCLES, the block goes to DONE with meas_timeout = 1, meas_n = edge_cnt (0 if the timeout occurs in ARM), meas_coarse = coarse_cnt (0 if in ARM) and meas_ovf unchanged. Handshake as in normal DONE.
- Undefined: no idle counter. The block waits indefinitely in ARM or COUNT. meas_timeout is tied to 0.

Test Plan:
1. Sensor period 20 clk (50% duty), n_cycles = 400, enable = 1: meas_valid rises; meas_coarse = 8000, meas_n = 400, ovf = 0, timeout = 0. Hold meas_ack low for 50 cycles: outputs stay stable. Pulse ack: valid falls on the next cycle and the next result is again 8000.
2. n_cycles = 0, sensor period 37 clk: meas_n = 1, meas_coarse = 37.
3. COARSE_WIDTH = 8, n_cycles = 10, period 40 clk: meas_coarse = 255, meas_ovf = 1.
4. Drop enable for 1 cycle mid-COUNT: no meas_valid for that run. busy falls. The run restarts on the next edge after enable returns and yields the correct count.
5. meas_ack pulsed while meas_valid = 0: no effect. Assert rst_n = 0 mid-COUNT: all outputs 0 immediately, state IDLE.
6. With RECIP_TIMEOUT_EN and TIMEOUT_CYCLES = 1000: stop the sensor after 3 periods of 20 clk, n_cycles = 10 → meas_timeout = 1, meas_n = 3, meas_coarse = 1060. With no sensor edges at all → meas_n = 0, meas_coarse = 0. Without the macro: the block stays busy and meas_valid stays 0.
